router_nport: RTL and testbench

- Single-clock packet router: one byte-stream input port, NUM_PORTS output channels.
- Parametrised successor of the fixed 3-port router top, with configurable data width, FIFO depth, channel count and read timeout.
- Decodes the header and writes the packet into the addressed output FIFO.
- Checks the trailing parity beat, discards packets with an invalid address, and flushes any channel whose consumer stalls past TIMEOUT cycles.

---
 rtl/router_nport_if.sv | 39 +++
 rtl/router_nport.sv | 200 ++++++++++++++++++++
 tb/tb_router_nport.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/router_nport_if.sv
// ----------------------------------------------------------------------------
// router_nport_if
//   Bundles the byte-stream input and the per-channel output signals of
//   router_nport. Clock and reset are not part of the bundle.
//
//   pkt_valid  source -> router  qualifies data_in
//   data_in    source -> router  header, payload or parity beat
//   read_enb   sink   -> router  per-channel pop request
//   data_out   router -> sink    channel p in bits [p*DATA_W +: DATA_W]
//   valid_out  router -> sink    channel FIFO non-empty
//   busy       router -> source  input stall, source holds the beat
//   error      router -> source  one-cycle pulse on parity mismatch
//   drop       router -> source  one-cycle pulse when a packet is discarded
//
//   Modports: master = traffic source/sink side, slave = router side.
// ----------------------------------------------------------------------------
interface router_nport_if #(
    parameter int NUM_PORTS = 3,
    parameter int DATA_W    = 8
);
    logic                          pkt_valid;
    logic [DATA_W-1:0]             data_in;
    logic [NUM_PORTS-1:0]          read_enb;
    logic [NUM_PORTS*DATA_W-1:0]   data_out;
    logic [NUM_PORTS-1:0]          valid_out;
    logic                          busy;
    logic                          error;
    logic                          drop;

    modport master (
        output pkt_valid, data_in, read_enb,
        input  data_out, valid_out, busy, error, drop
    );

    modport slave (
        input  pkt_valid, data_in, read_enb,
        output data_out, valid_out, busy, error, drop
    );
endinterface

// File: rtl/router_nport.sv
// ----------------------------------------------------------------------------
// router_nport
//   Single-clock packet router: one byte-stream input, NUM_PORTS output
//   channels, each backed by a FIFO_DEPTH-entry FIFO. A packet is a header
//   (dest in the low ADDR_W bits, LEN above), LEN payload beats and one
//   parity beat (XOR of header and payload). Header and payload are written
//   into FIFO[dest]; the parity beat is only checked. Packets with an
//   invalid dest are consumed and discarded. A channel whose data sits
//   unread for TIMEOUT cycles is flushed.
//
//   Ports:
//     clock  rising-edge system clock
//     reset  asynchronous, active-high reset
//     bus    router_nport_if.slave (see interface header for signals)
// ----------------------------------------------------------------------------
module router_nport #(
    parameter int NUM_PORTS  = 3,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = 30
) (
    input  logic          clock,
    input  logic          reset,
    router_nport_if.slave bus
);
    localparam int ADDR_W = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1;
    localparam int LEN_W  = DATA_W - ADDR_W;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int TMO_W  = $clog2(TIMEOUT + 1);
    // Every encodable dest gets a slot so lookups never index out of range.
    localparam int NSLOT  = 1 << ADDR_W;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PARITY, S_DROP} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] dest_q;
    logic [LEN_W-1:0]  rem_q;     // payload beats still to come
    logic [DATA_W-1:0] par_q;
    logic              error_q;
    logic              drop_q;

    logic [DATA_W-1:0] mem      [NUM_PORTS][FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q [NUM_PORTS];
    logic [PTR_W-1:0]  rd_ptr_q [NUM_PORTS];
    logic [CNT_W-1:0]  cnt_q    [NUM_PORTS];
    logic [TMO_W-1:0]  tmo_q    [NUM_PORTS];
    logic [DATA_W-1:0] dout_q   [NUM_PORTS];

    logic [NUM_PORTS-1:0] full, empty, flush, rd_en, wr_en;
    logic [NSLOT-1:0]     full_x, flush_x;
    logic [ADDR_W-1:0]    hdr_dest, tgt;
    logic [LEN_W-1:0]     hdr_len;
    logic                 hdr_ok, routing, busy, accept;

    assign hdr_dest = bus.data_in[ADDR_W-1:0];
    assign hdr_len  = bus.data_in[DATA_W-1:ADDR_W];
    assign hdr_ok   = (int'(hdr_dest) < NUM_PORTS);

    always_comb begin : port_status
        // NOTE: each combinational output gets a default before any branch,
        // so no path leaves it unassigned and infers a latch.
        full  = '0;
        empty = '0;
        flush = '0;
        rd_en = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            full[p]  = (cnt_q[p] == CNT_W'(FIFO_DEPTH));
            empty[p] = (cnt_q[p] == '0);
            flush[p] = (tmo_q[p] == TMO_W'(TIMEOUT));
            rd_en[p] = bus.read_enb[p] && !empty[p];
        end
    end

    assign full_x  = NSLOT'(full);
    assign flush_x = NSLOT'(flush);

    // The header picks its channel straight from data_in; later beats use the
    // latched dest. Only states that write into a FIFO can stall the source.
    assign tgt     = (state_q == S_IDLE) ? hdr_dest : dest_q;
    assign routing = ((state_q == S_IDLE) && hdr_ok) || (state_q == S_LOAD);
    assign busy    = bus.pkt_valid && routing && full_x[tgt];
    assign accept  = bus.pkt_valid && !busy;

    always_comb begin : write_select
        wr_en = '0;
        for (int p = 0; p < NUM_PORTS; p++)
            wr_en[p] = accept && routing && (tgt == ADDR_W'(p));
    end

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            dest_q  <= '0;
            rem_q   <= '0;
            par_q   <= '0;
            error_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // branch below sees the values from before this edge.
            error_q <= 1'b0;
            drop_q  <= |flush;
            case (state_q)
                S_IDLE: if (accept) begin
                    dest_q <= hdr_dest;
                    rem_q  <= hdr_len;
                    par_q  <= bus.data_in;
                    // A header landing on a channel being flushed is lost
                    // with it, so the rest of that packet is discarded too.
                    if (!hdr_ok || flush_x[hdr_dest]) begin
                        state_q <= S_DROP;
                        drop_q  <= 1'b1;
                    end else begin
                        state_q <= (hdr_len == '0) ? S_PARITY : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (flush_x[dest_q]) begin
                        // A beat accepted this cycle was flushed, not stored.
                        state_q <= S_DROP;
                        if (accept) rem_q <= rem_q - LEN_W'(1);
                    end else if (accept) begin
                        par_q <= par_q ^ bus.data_in;
                        rem_q <= rem_q - LEN_W'(1);
                        if (rem_q == LEN_W'(1)) state_q <= S_PARITY;
                    end
                end
                S_PARITY: begin
                    if (flush_x[dest_q]) begin
                        // Packet already discarded: no parity verdict.
                        state_q <= accept ? S_IDLE : S_DROP;
                        rem_q   <= '0;
                    end else if (accept) begin
                        error_q <= (bus.data_in != par_q);
                        state_q <= S_IDLE;
                    end
                end
                S_DROP: if (accept) begin
                    // rem_q == 0 means this beat is the parity beat.
                    if (rem_q == '0) state_q <= S_IDLE;
                    else             rem_q   <= rem_q - LEN_W'(1);
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------- FIFO storage
    // NOTE: the data array has no reset; pointers and counts define which
    // entries are meaningful, and a reset here would block RAM mapping.
    always_ff @(posedge clock) begin
        for (int p = 0; p < NUM_PORTS; p++)
            if (wr_en[p] && !flush[p]) mem[p][wr_ptr_q[p]] <= bus.data_in;
    end

    // ------------------------------------- FIFO control and timeouts
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                wr_ptr_q[p] <= '0;
                rd_ptr_q[p] <= '0;
                cnt_q[p]    <= '0;
                tmo_q[p]    <= '0;
                dout_q[p]   <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (flush[p]) begin
                    // Flush wins over a same-cycle read or write; data_out holds.
                    wr_ptr_q[p] <= '0;
                    rd_ptr_q[p] <= '0;
                    cnt_q[p]    <= '0;
                    tmo_q[p]    <= '0;
                end else begin
                    if (wr_en[p]) wr_ptr_q[p] <= wr_ptr_q[p] + PTR_W'(1);
                    if (rd_en[p]) begin
                        rd_ptr_q[p] <= rd_ptr_q[p] + PTR_W'(1);
                        dout_q[p]   <= mem[p][rd_ptr_q[p]];
                    end
                    cnt_q[p] <= cnt_q[p] + CNT_W'(wr_en[p]) - CNT_W'(rd_en[p]);
                    tmo_q[p] <= (rd_en[p] || empty[p]) ? '0 : tmo_q[p] + TMO_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------ outputs
    always_comb begin : pack_out
        bus.data_out = '0;
        for (int p = 0; p < NUM_PORTS; p++)
            bus.data_out[p*DATA_W +: DATA_W] = dout_q[p];
    end

    assign bus.valid_out = ~empty;
    assign bus.busy      = busy;
    assign bus.error     = error_q;
    assign bus.drop      = drop_q;
endmodule

// File: tb/tb_router_nport.sv
// ----------------------------------------------------------------------------
// tb_router_nport
//   Directed bench for router_nport. Instance a uses the default 16-deep
//   FIFOs, instance b uses 4-deep FIFOs for the back-pressure steps.
//   Expected channel bytes are pushed into a per-channel queue when the beat
//   is driven and popped when the bench reads that channel.
// ----------------------------------------------------------------------------
module tb_router_nport;
    localparam int NP = 3;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    router_nport_if #(.NUM_PORTS(NP), .DATA_W(DW)) if_a ();
    router_nport_if #(.NUM_PORTS(NP), .DATA_W(DW)) if_b ();

    router_nport #(.NUM_PORTS(NP), .DATA_W(DW), .FIFO_DEPTH(16), .TIMEOUT(30)) u_a (
        .clock (clk),
        .reset (rst),
        .bus   (if_a.slave)
    );

    router_nport #(.NUM_PORTS(NP), .DATA_W(DW), .FIFO_DEPTH(4), .TIMEOUT(30)) u_b (
        .clock (clk),
        .reset (rst),
        .bus   (if_b.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Pulse / level tallies, sampled on the falling edge.
    int err_a = 0, drop_a = 0, busy_a = 0, err_b = 0, v2_cycles = 0;

    logic [7:0] exp_q    [2][NP][$];
    logic [7:0] last_val [2][NP];

    always @(negedge clk) begin
        if (!rst) begin
            if (if_a.error)        err_a++;
            if (if_a.drop)         drop_a++;
            if (if_a.busy)         busy_a++;
            if (if_b.error)        err_b++;
            if (if_a.valid_out[2]) v2_cycles++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic get_busy(input bit sel);
        return sel ? if_b.busy : if_a.busy;
    endfunction

    function automatic logic get_valid(input bit sel, input int p);
        return sel ? if_b.valid_out[p] : if_a.valid_out[p];
    endfunction

    function automatic logic [7:0] get_dout(input bit sel, input int p);
        return sel ? if_b.data_out[p*DW +: DW] : if_a.data_out[p*DW +: DW];
    endfunction

    task automatic drive(input bit sel, input logic v, input logic [7:0] b);
        if (sel) begin if_b.pkt_valid = v; if_b.data_in = b; end
        else     begin if_a.pkt_valid = v; if_a.data_in = b; end
    endtask

    task automatic set_rd(input bit sel, input int p, input logic v);
        if (sel) if_b.read_enb[p] = v;
        else     if_a.read_enb[p] = v;
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic send(input bit sel, input logic [7:0] b);
        bit done = 1'b0;
        @(negedge clk);
        drive(sel, 1'b1, b);
        for (int i = 0; i < 50 && !done; i++) begin
            #1;
            if (!get_busy(sel)) begin @(posedge clk); done = 1'b1; end
            else @(negedge clk);
        end
        #1;
        drive(sel, 1'b0, 8'h00);
        check("send_accepted", done, 1'b1);
    endtask

    // Compare data_out against the next expected byte, or against the
    // held value when nothing is expected.
    task automatic pop_expect(input bit sel, input int p, input string tag);
        logic [7:0] e;
        if (exp_q[sel][p].size() > 0) begin
            e = exp_q[sel][p].pop_front();
            last_val[sel][p] = e;
            check(tag, get_dout(sel, p), e);
        end else begin
            check({tag, "_hold"}, get_dout(sel, p), last_val[sel][p]);
        end
    endtask

    task automatic pop(input bit sel, input int p, input string tag);
        @(negedge clk);
        check({tag, "_valid"}, get_valid(sel, p), exp_q[sel][p].size() != 0);
        set_rd(sel, p, 1'b1);
        @(posedge clk);
        #1;
        set_rd(sel, p, 1'b0);
        pop_expect(sel, p, tag);
    endtask

    // Send header, LEN payload beats base, base+1, ... and the parity beat
    // (XOR of header and payload, optionally corrupted by flip).
    task automatic send_pkt(input bit sel, input logic [7:0] hdr, input logic [7:0] base,
                            input logic [7:0] flip);
        int         dest = int'(hdr[1:0]);
        int         len  = int'(hdr[7:2]);
        logic [7:0] par  = hdr;
        logic [7:0] b;
        if (dest < NP) exp_q[sel][dest].push_back(hdr);
        send(sel, hdr);
        for (int i = 0; i < len; i++) begin
            b   = base + 8'(i);
            par = par ^ b;
            if (dest < NP) exp_q[sel][dest].push_back(b);
            send(sel, b);
        end
        send(sel, par ^ flip);
    endtask

    // Instance b only: hold a beat, popping channel 0 while it is stalled.
    task automatic send_drain(input logic [7:0] b, input string tag);
        bit done = 1'b0;
        @(negedge clk);
        drive(1'b1, 1'b1, b);
        for (int i = 0; i < 20 && !done; i++) begin
            #1;
            if (!if_b.busy) begin
                @(posedge clk);
                done = 1'b1;
            end else begin
                if_b.read_enb[0] = 1'b1;
                @(posedge clk);
                #1;
                if_b.read_enb[0] = 1'b0;
                pop_expect(1'b1, 0, tag);
            end
        end
        #1;
        drive(1'b1, 1'b0, 8'h00);
        check({tag, "_accepted"}, done, 1'b1);
    endtask

    initial begin
        int         e0, d0, b0;
        logic [7:0] par;

        rst = 1'b1;
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h00);
        if_a.read_enb = '0;
        if_b.read_enb = '0;
        for (int s = 0; s < 2; s++)
            for (int p = 0; p < NP; p++) last_val[s][p] = 8'h00;

        // ---------------- reset state
        repeat (2) @(negedge clk);
        check("rst_valid_a", if_a.valid_out, 3'b000);
        check("rst_dout_a",  if_a.data_out, 24'h0);
        check("rst_busy_a",  if_a.busy, 1'b0);
        check("rst_error_a", if_a.error, 1'b0);
        check("rst_drop_a",  if_a.drop, 1'b0);
        check("rst_valid_b", if_b.valid_out, 3'b000);
        rst = 1'b0;

        // ---------------- basic route to channel 1: 15, 01..05, parity 14
        e0 = err_a; b0 = busy_a;
        send_pkt(1'b0, 8'h15, 8'h01, 8'h00);
        check("t1_valid", if_a.valid_out, 3'b010);
        for (int i = 0; i < 7; i++) pop(1'b0, 1, "t1_pop");
        check("t1_valid_empty", if_a.valid_out, 3'b000);
        check("t1_no_error", err_a - e0, 0);
        check("t1_no_busy",  busy_a - b0, 0);

        // ---------------- parity error: 0x11 instead of 0x14
        e0 = err_a;
        send_pkt(1'b0, 8'h15, 8'h01, 8'h05);
        check("t2_error_pulse", if_a.error, 1'b1);
        @(posedge clk); #1;
        check("t2_error_clear", if_a.error, 1'b0);
        check("t2_error_once", err_a - e0, 1);
        for (int i = 0; i < 6; i++) pop(1'b0, 1, "t2_pop");

        // ---------------- invalid dest 3, LEN 2: consumed and dropped
        d0 = drop_a;
        send(1'b0, 8'h0B);
        check("t3_drop_pulse", if_a.drop, 1'b1);
        send(1'b0, 8'h50);
        send(1'b0, 8'h51);
        send(1'b0, 8'h5A);
        @(negedge clk);
        check("t3_drop_once", drop_a - d0, 1);
        check("t3_no_valid", if_a.valid_out, 3'b000);
        send_pkt(1'b0, 8'h08, 8'hAA, 8'h00);
        check("t3_next_valid", if_a.valid_out, 3'b001);
        for (int i = 0; i < 3; i++) pop(1'b0, 0, "t3_pop");

        // ---------------- 4-deep FIFO back-pressure on instance b
        par = 8'h20;
        exp_q[1][0].push_back(8'h20);
        send(1'b1, 8'h20);
        for (int i = 0; i < 3; i++) begin
            exp_q[1][0].push_back(8'h31 + 8'(i));
            par = par ^ (8'h31 + 8'(i));
            send(1'b1, 8'h31 + 8'(i));
        end
        @(negedge clk);
        exp_q[1][0].push_back(8'h34);
        par = par ^ 8'h34;
        drive(1'b1, 1'b1, 8'h34);
        #1;
        check("t4_busy_full", if_b.busy, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        check("t4_busy_hold", if_b.busy, 1'b1);
        // Single read pulse: the stalled write does not use the freed slot
        // in the same cycle, but is accepted on the next edge.
        if_b.read_enb[0] = 1'b1;
        @(posedge clk); #1;
        if_b.read_enb[0] = 1'b0;
        pop_expect(1'b1, 0, "t4_pop_hdr");
        check("t4_busy_released", if_b.busy, 1'b0);
        @(posedge clk); #1;
        exp_q[1][0].push_back(8'h35);
        par = par ^ 8'h35;
        drive(1'b1, 1'b1, 8'h35);
        #1;
        check("t4_one_beat", if_b.busy, 1'b1);
        send_drain(8'h35, "t4_drain");
        for (int i = 0; i < 3; i++) begin
            exp_q[1][0].push_back(8'h36 + 8'(i));
            par = par ^ (8'h36 + 8'(i));
            send_drain(8'h36 + 8'(i), "t4_drain");
        end
        send_drain(par, "t4_parity");
        for (int i = 0; i < 16 && exp_q[1][0].size() > 0; i++) pop(1'b1, 0, "t4_tail");
        pop(1'b1, 0, "t4_empty");
        check("t4_no_error", err_b, 0);

        // ---------------- timeout flush of channel 2
        v2_cycles = 0;
        send_pkt(1'b0, 8'h0E, 8'h41, 8'h00);
        check("t5_valid2", if_a.valid_out[2], 1'b1);
        send_pkt(1'b0, 8'h05, 8'h77, 8'h00);
        pop(1'b0, 1, "t5_ch1");
        pop(1'b0, 1, "t5_ch1");
        for (int i = 0; i < 60 && if_a.valid_out[2]; i++) @(negedge clk);
        #1;
        check("t5_flushed", if_a.valid_out[2], 1'b0);
        // valid_out[2] rises after the header edge, the counter reaches 30
        // 30 edges later, and the flush lands on the edge after that.
        check("t5_valid_cycles", v2_cycles, 31);
        check("t5_dout2_held", if_a.data_out[2*DW +: DW], 8'h00);
        check("t5_others_idle", if_a.valid_out[1:0], 2'b00);
        exp_q[0][2].delete();
        send_pkt(1'b0, 8'h04, 8'h60, 8'h00);
        pop(1'b0, 0, "t5_ch0");
        pop(1'b0, 0, "t5_ch0");

        // ---------------- reset mid-LOAD
        exp_q[0][1].push_back(8'h15);
        send(1'b0, 8'h15);
        send(1'b0, 8'h01);
        send(1'b0, 8'h02);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_valid", if_a.valid_out, 3'b000);
        check("t6_rst_dout",  if_a.data_out, 24'h0);
        check("t6_rst_busy",  if_a.busy, 1'b0);
        check("t6_rst_dout_b", if_b.data_out, 24'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 2; s++)
            for (int p = 0; p < NP; p++) begin
                exp_q[s][p].delete();
                last_val[s][p] = 8'h00;
            end
        e0 = err_a;
        send_pkt(1'b0, 8'h04, 8'h99, 8'h00);
        check("t6_valid", if_a.valid_out, 3'b001);
        pop(1'b0, 0, "t6_pop");
        pop(1'b0, 0, "t6_pop");
        check("t6_no_error", err_a - e0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
